// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI memory slave: response codes,
// write/read channel state encodings and the write-response helper.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // A burst is clean only when the beat count and wlast agree on the final beat.
    function automatic logic [1:0] write_resp(input logic range_err,
                                              input logic len_hit,
                                              input logic last_seen);
        logic [1:0] resp;
        if (range_err) begin
            resp = RESP_DECERR;
        end else if (len_hit && last_seen) begin
            resp = RESP_OKAY;
        end else begin
            resp = RESP_SLVERR;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Byte-enable RAM: one write port, one read port with a registered output
// that only updates when re is high (holds data across read stalls).
// A same-cycle write and read of one word returns the pre-write contents.
module axi_mem_ram #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_BITS-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [ADDR_BITS-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int BYTE_W = 8;
    localparam int DEPTH  = 32'd1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Write only the strobed bytes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH / BYTE_W; i++) begin
                if (wbe[i]) begin
                    mem_r[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Registered read; output holds when no new read is requested.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: INCR full-width bursts into a 2^MEM_ADDR_BITS x 128-bit
// RAM, independent write and read channels, one transaction outstanding each.
// Optional feature macro: AXI_MEM_RANGE_CHK_EN -- addresses with nonzero bits
// above the memory range answer DECERR (writes dropped, reads return zero).
// Without it those upper bits are ignored and addresses alias.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 12,
    parameter int C_S_AXI_ADDR_WIDTH = 29,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int MEM_ADDR_BITS      = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int AW = MEM_ADDR_BITS;
    localparam logic [AW-1:0] ONE_WORD = {{(AW-1){1'b0}}, 1'b1};

    // ---------------- write channel state ----------------
    w_state_t                    w_state_r, w_state_nx_s;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id_r;
    logic [AW-1:0]               w_addr_r;
    logic [7:0]                  w_len_r, w_cnt_r;
    logic                        w_dec_r;
    logic [1:0]                  w_resp_r;
    logic                        aw_hs_s, w_hs_s, w_len_hit_s, w_final_s, aw_dec_s;

    // ---------------- read channel state ----------------
    r_state_t                    r_state_r, r_state_nx_s;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id_r;
    logic [AW-1:0]               r_addr_r;
    logic [7:0]                  r_len_r, r_cnt_r;
    logic                        r_dec_r;
    logic                        ar_hs_s, r_hs_s, r_last_s, ar_dec_s;
    logic [AW-1:0]               ar_word_s;

    // ---------------- RAM interface ----------------
    logic                          ram_we_s, ram_re_s;
    logic [AW-1:0]                 ram_raddr_s;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rdata_s;

    // Byte offset bits and (optionally) upper bits never reach the RAM.
    logic unused_s;
    assign unused_s = ^{s_axi_awaddr, s_axi_araddr};

`ifdef AXI_MEM_RANGE_CHK_EN
    assign aw_dec_s = |s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_BITS+4];
    assign ar_dec_s = |s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_BITS+4];
`else
    assign aw_dec_s = 1'b0;
    assign ar_dec_s = 1'b0;
`endif

    assign aw_hs_s     = s_axi_awvalid && (w_state_r == W_IDLE);
    assign w_hs_s      = s_axi_wvalid  && (w_state_r == W_DATA);
    assign w_len_hit_s = (w_cnt_r == w_len_r);
    assign w_final_s   = w_len_hit_s || s_axi_wlast;

    assign s_axi_awready = (w_state_r == W_IDLE);
    assign s_axi_wready  = (w_state_r == W_DATA);
    assign s_axi_bvalid  = (w_state_r == W_RESP);
    assign s_axi_bid     = w_id_r;
    assign s_axi_bresp   = w_resp_r;

    // Write channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_nx_s;
        end
    end

    // Write channel next-state logic.
    always_comb begin
        w_state_nx_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (s_axi_awvalid) w_state_nx_s = W_DATA;
                else               w_state_nx_s = W_IDLE;
            end
            W_DATA: begin
                if (s_axi_wvalid && w_final_s) w_state_nx_s = W_RESP;
                else                           w_state_nx_s = W_DATA;
            end
            W_RESP: begin
                if (s_axi_bready) w_state_nx_s = W_IDLE;
                else              w_state_nx_s = W_RESP;
            end
            default: w_state_nx_s = W_IDLE;
        endcase
    end

    // Write burst bookkeeping: latch AW fields, step address per beat, set response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_id_r   <= {C_S_AXI_ID_WIDTH{1'b0}};
            w_addr_r <= {AW{1'b0}};
            w_len_r  <= 8'd0;
            w_cnt_r  <= 8'd0;
            w_dec_r  <= 1'b0;
            w_resp_r <= RESP_OKAY;
        end else if (aw_hs_s) begin
            w_id_r   <= s_axi_awid;
            w_addr_r <= s_axi_awaddr[MEM_ADDR_BITS+3:4];
            w_len_r  <= s_axi_awlen;
            w_cnt_r  <= 8'd0;
            w_dec_r  <= aw_dec_s;
        end else if (w_hs_s) begin
            w_addr_r <= w_addr_r + ONE_WORD;
            w_cnt_r  <= w_cnt_r + 8'd1;
            if (w_final_s) begin
                w_resp_r <= write_resp(w_dec_r, w_len_hit_s, s_axi_wlast);
            end
        end
    end

    assign ram_we_s = w_hs_s && !w_dec_r && !rst;

    // ---------------- read channel ----------------
    assign ar_word_s = s_axi_araddr[MEM_ADDR_BITS+3:4];
    assign ar_hs_s   = s_axi_arvalid && (r_state_r == R_IDLE);
    assign r_hs_s    = s_axi_rvalid && s_axi_rready;
    assign r_last_s  = (r_state_r == R_DATA) && (r_cnt_r == r_len_r);

    assign s_axi_arready = (r_state_r == R_IDLE);
    assign s_axi_rvalid  = (r_state_r == R_DATA);
    assign s_axi_rlast   = r_last_s;
    assign s_axi_rid     = r_id_r;
    assign s_axi_rdata   = r_dec_r ? {C_S_AXI_DATA_WIDTH{1'b0}} : ram_rdata_s;
    assign s_axi_rresp   = (s_axi_rvalid && r_dec_r) ? RESP_DECERR : RESP_OKAY;

    // Read channel state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_nx_s;
        end
    end

    // Read channel next-state logic.
    always_comb begin
        r_state_nx_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (s_axi_arvalid) r_state_nx_s = R_DATA;
                else               r_state_nx_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && r_last_s) r_state_nx_s = R_IDLE;
                else                    r_state_nx_s = R_DATA;
            end
            default: r_state_nx_s = R_IDLE;
        endcase
    end

    // Read burst bookkeeping: latch AR fields, advance beat on each R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_r   <= {C_S_AXI_ID_WIDTH{1'b0}};
            r_addr_r <= {AW{1'b0}};
            r_len_r  <= 8'd0;
            r_cnt_r  <= 8'd0;
            r_dec_r  <= 1'b0;
        end else if (ar_hs_s) begin
            r_id_r   <= s_axi_arid;
            r_addr_r <= ar_word_s;
            r_len_r  <= s_axi_arlen;
            r_cnt_r  <= 8'd0;
            r_dec_r  <= ar_dec_s;
        end else if (r_hs_s && !r_last_s) begin
            r_addr_r <= r_addr_r + ONE_WORD;
            r_cnt_r  <= r_cnt_r + 8'd1;
        end
    end

    // Prefetch: fetch the first word on AR, the next word whenever a beat is taken.
    always_comb begin
        ram_re_s    = 1'b0;
        ram_raddr_s = r_addr_r + ONE_WORD;
        if (ar_hs_s) begin
            ram_re_s    = 1'b1;
            ram_raddr_s = ar_word_s;
        end else begin
            ram_re_s    = r_hs_s && !r_last_s;
            ram_raddr_s = r_addr_r + ONE_WORD;
        end
    end

    axi_mem_ram #(
        .ADDR_BITS (MEM_ADDR_BITS),
        .DATA_WIDTH(C_S_AXI_DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .waddr(w_addr_r),
        .wdata(s_axi_wdata),
        .wbe  (s_axi_wstrb),
        .re   (ram_re_s),
        .raddr(ram_raddr_s),
        .rdata(ram_rdata_s)
    );

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized self-checking bench for axi_mem_slave against a byte-level
// memory model. Honours AXI_MEM_RANGE_CHK_EN when defined.
module tb_axi_mem_slave;

    logic          clk = 1'b0;
    logic          rst;
    logic [11:0]   s_axi_awid;
    logic [28:0]   s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [127:0]  s_axi_wdata;
    logic [15:0]   s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [11:0]   s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [11:0]   s_axi_arid;
    logic [28:0]   s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [11:0]   s_axi_rid;
    logic [127:0]  s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    int errors = 0;
    int checks = 0;

    logic [127:0] mem_model [0:1023];

    axi_mem_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_dec(input logic [28:0] a);
`ifdef AXI_MEM_RANGE_CHK_EN
        return (a >> 14) != 29'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_of(input logic [28:0] a);
        return int'((a >> 4) % 29'd1024);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_aw(input logic [11:0] id, input logic [28:0] addr, input int len);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awvalid = 1'b1;
        while (s_axi_awready !== 1'b1 && n < 64) begin tick(); n++; end
        check_eq("aw_ready", s_axi_awready, 1'b1);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [127:0] data, input logic [15:0] strb,
                          input bit last, input int gap);
        int n = 0;
        repeat (gap) tick();
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (s_axi_wready !== 1'b1 && n < 64) begin tick(); n++; end
        check_eq("w_ready", s_axi_wready, 1'b1);
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic recv_b(input logic [11:0] id, input logic [1:0] resp, input int hold);
        s_axi_bready = 1'b0;
        repeat (hold) begin
            check_eq("b_hold_valid", s_axi_bvalid, 1'b1);
            check_eq("b_hold_resp", s_axi_bresp, resp);
            tick();
        end
        check_eq("b_valid", s_axi_bvalid, 1'b1);
        check_eq("b_id", s_axi_bid, id);
        check_eq("b_resp", s_axi_bresp, resp);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_eq("b_drop", s_axi_bvalid, 1'b0);
        check_eq("aw_ready_back", s_axi_awready, 1'b1);
    endtask

    // wlast is driven on beat index wlast_at (beyond len means never).
    task automatic do_write(input logic [11:0] id, input logic [28:0] addr, input int len,
                            input int wlast_at, input bit full_strb, input bit seq_data,
                            input bit gaps, input int bhold);
        bit dec = is_dec(addr);
        int word = word_of(addr);
        int nb = ((wlast_at < len) ? wlast_at : len) + 1;
        logic [1:0] exp_resp = dec ? 2'b11 : ((wlast_at == len) ? 2'b00 : 2'b10);
        send_aw(id, addr, len);
        for (int i = 0; i < nb; i++) begin
            logic [127:0] d = seq_data ? 128'(i + 1) : rnd128();
            logic [15:0]  s = full_strb ? 16'hFFFF : 16'($urandom);
            int w = (word + i) % 1024;
            send_w(d, s, i == wlast_at, gaps ? int'($urandom_range(0, 2)) : 0);
            if (!dec) begin
                for (int b = 0; b < 16; b++) begin
                    if (s[b]) mem_model[w][b*8 +: 8] = d[b*8 +: 8];
                end
            end
        end
        check_eq("b_rise", s_axi_bvalid, 1'b1);
        check_eq("w_ready_off", s_axi_wready, 1'b0);
        recv_b(id, exp_resp, bhold);
    endtask

    // mode 0: rready always 1; 1: 1010...; 2: random.
    task automatic do_read(input logic [11:0] id, input logic [28:0] addr, input int len,
                           input int mode);
        bit dec = is_dec(addr);
        int word = word_of(addr);
        int n = 0;
        int b = 0;
        int cyc = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arvalid = 1'b1;
        while (s_axi_arready !== 1'b1 && n < 64) begin tick(); n++; end
        check_eq("ar_ready", s_axi_arready, 1'b1);
        tick();
        s_axi_arvalid = 1'b0;
        while (b <= len && cyc < 4000) begin
            bit rr = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
            logic [127:0] expd = dec ? 128'd0 : mem_model[(word + b) % 1024];
            s_axi_rready = rr;
            check_eq("r_valid", s_axi_rvalid, 1'b1);
            if (s_axi_rvalid !== 1'b1) break;
            check_eq("r_data", s_axi_rdata, expd);
            check_eq("r_last", s_axi_rlast, b == len);
            check_eq("r_id", s_axi_rid, id);
            check_eq("r_resp", s_axi_rresp, dec ? 2'b11 : 2'b00);
            tick();
            if (rr) b++;
            cyc++;
        end
        s_axi_rready = 1'b0;
        check_eq("r_beats", b, len + 1);
        check_eq("r_idle", s_axi_rvalid, 1'b0);
        check_eq("ar_ready_back", s_axi_arready, 1'b1);
    endtask

    initial begin
        logic [127:0] old_v, new_v;
        rst = 1'b1;
        s_axi_awid = 12'd0; s_axi_awaddr = 29'd0; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b0;
        s_axi_wdata = 128'd0; s_axi_wstrb = 16'd0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = 12'd0; s_axi_araddr = 29'd0; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_awready", s_axi_awready, 1'b1);
        check_eq("rst_arready", s_axi_arready, 1'b1);
        check_eq("rst_wready", s_axi_wready, 1'b0);
        check_eq("rst_bvalid", s_axi_bvalid, 1'b0);
        check_eq("rst_rvalid", s_axi_rvalid, 1'b0);
        check_eq("rst_rlast", s_axi_rlast, 1'b0);
        check_eq("rst_bresp", s_axi_bresp, 2'b00);
        check_eq("rst_rresp", s_axi_rresp, 2'b00);

        // Fill the whole memory so every later read has a known expectation.
        for (int k = 0; k < 4; k++) begin
            do_write(12'(k), 29'(k * 4096), 255, 255, 1'b1, 1'b0, 1'b0, 0);
        end

        // Basic 4-beat write then readback.
        do_write(12'hA5C, 29'h100, 3, 3, 1'b1, 1'b1, 1'b0, 0);
        do_read(12'h3C1, 29'h100, 3, 0);

        // Partial strobe over word 0.
        old_v = mem_model[0];
        do_write(12'h011, 29'h0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        old_v = mem_model[0];
        s_axi_awid = 12'h012;
        send_aw(12'h012, 29'h0, 0);
        send_w({128{1'b1}}, 16'h000F, 1'b1, 0);
        mem_model[0][31:0] = 32'hFFFF_FFFF;
        check_eq("strb_model", mem_model[0], {old_v[127:32], 32'hFFFF_FFFF});
        recv_b(12'h012, 2'b00, 1);
        do_read(12'h013, 29'h0, 0, 0);

        // Early wlast on beat 2 of a 4-beat burst, and missing wlast.
        do_write(12'h7E1, 29'h300, 3, 1, 1'b1, 1'b0, 1'b0, 2);
        do_read(12'h7E2, 29'h300, 3, 0);
        do_write(12'h7E3, 29'h400, 1, 9, 1'b0, 1'b0, 1'b1, 0);

        // 8-beat read with rready toggling.
        do_read(12'h042, 29'h200, 7, 1);

        // Word-index wrap at the top of memory.
        do_write(12'h0AA, 29'h3FE0, 3, 3, 1'b0, 1'b0, 1'b1, 1);
        do_read(12'h0AB, 29'h3FE0, 3, 2);

        // Upper address bits: alias normally, DECERR with range checking.
        do_write(12'h0D1, 29'h0100_0200, 1, 1, 1'b1, 1'b0, 1'b0, 0);
        do_read(12'h0D2, 29'h0100_0000, 1, 0);
        do_read(12'h0D3, 29'h0000_0200, 1, 0);

        // Same-word write and read in one cycle returns pre-write data.
        old_v = mem_model[12'h055];
        new_v = rnd128();
        send_aw(12'h0E0, 29'h550, 0);
        s_axi_wdata = new_v; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_arid = 12'h0E1; s_axi_araddr = 29'h550; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        s_axi_rready = 1'b0;
        check_eq("rw_wready", s_axi_wready, 1'b1);
        check_eq("rw_arready", s_axi_arready, 1'b1);
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        check_eq("rw_rvalid", s_axi_rvalid, 1'b1);
        check_eq("rw_pre_write", s_axi_rdata, old_v);
        mem_model[12'h055] = new_v;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        recv_b(12'h0E0, 2'b00, 0);
        do_read(12'h0E2, 29'h550, 0, 0);

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            logic [28:0] a = 29'(($urandom_range(0, 1023) << 4) | $urandom_range(0, 15));
            int len = $urandom_range(0, 15);
            int wl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16)) : len;
            if ($urandom_range(0, 5) == 0) a = a | 29'h0100_0000;
            do_write(12'($urandom), a, len, wl, 1'b0, 1'b0, 1'b1, $urandom_range(0, 3));
            a = 29'($urandom_range(0, 1023) << 4);
            if ($urandom_range(0, 5) == 0) a = a | 29'h0080_0000;
            do_read(12'($urandom), a, $urandom_range(0, 15), $urandom_range(0, 2));
        end

        // Reset in the middle of a read burst.
        s_axi_arid = 12'h0F0; s_axi_araddr = 29'h0100_0800; s_axi_arlen = 8'd7;
        s_axi_arvalid = 1'b1;
        check_eq("mr_arready", s_axi_arready, 1'b1);
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        tick(); tick();
        s_axi_rready = 1'b0;
        check_eq("mr_rvalid", s_axi_rvalid, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("mr_rst_rvalid", s_axi_rvalid, 1'b0);
        check_eq("mr_rst_rlast", s_axi_rlast, 1'b0);
        check_eq("mr_rst_rresp", s_axi_rresp, 2'b00);
        rst = 1'b0;
        tick();
        check_eq("mr_arready", s_axi_arready, 1'b1);
        check_eq("mr_awready", s_axi_awready, 1'b1);

        // Reset in the middle of a write burst: no response, stored beat kept.
        new_v = rnd128();
        send_aw(12'h0F1, 29'h900, 3);
        send_w(new_v, 16'hFFFF, 1'b0, 0);
        mem_model[12'h090] = new_v;
        check_eq("mw_wready", s_axi_wready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mw_bvalid", s_axi_bvalid, 1'b0);
        check_eq("mw_wready_off", s_axi_wready, 1'b0);
        tick();
        check_eq("mw_bvalid2", s_axi_bvalid, 1'b0);
        check_eq("mw_awready", s_axi_awready, 1'b1);
        do_read(12'h0F2, 29'h900, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
